// File: rtl/jt10_adpcmb_dec_if.sv
// Bus bundle between the ADPCM-B address counter/controller and the nibble decoder.
// With JT10_ADPCMB_SATFLAG_EN defined the bundle also carries the sticky clamp flag.
interface jt10_adpcmb_dec_if;
   logic               cen;
   logic               adv;
   logic               chon;
   logic               clr;
   logic [7:0]         data;
   logic               nibble_sel;
   logic signed [15:0] pcm;
   logic               busy;
   logic               done;
`ifdef JT10_ADPCMB_SATFLAG_EN
   logic               sat;

   modport master (output cen, adv, chon, clr, data, nibble_sel,
                   input  pcm, busy, done, sat);
   modport slave  (input  cen, adv, chon, clr, data, nibble_sel,
                   output pcm, busy, done, sat);
`else
   modport master (output cen, adv, chon, clr, data, nibble_sel,
                   input  pcm, busy, done);
   modport slave  (input  cen, adv, chon, clr, data, nibble_sel,
                   output pcm, busy, done);
`endif
endinterface

// File: rtl/jt10_adpcmb_dec.sv
// YM2610 ADPCM-B nibble decoder using a serial shift-add multiplier (10 clocks per nibble).
// Optional sticky clamp flag on bus.sat when JT10_ADPCMB_SATFLAG_EN is defined.
module jt10_adpcmb_dec #(
   parameter int STEPW  = 15,
   parameter int MULCYC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   jt10_adpcmb_dec_if.slave bus
);
   localparam int PAW = STEPW + 4;
   localparam int PBW = STEPW + 8;
   localparam logic [2:0]       LAST     = 3'(MULCYC - 1);
   localparam logic [STEPW-1:0] STEP_MIN = STEPW'(127);
   localparam logic [STEPW-1:0] STEP_MAX = STEPW'(24576);

   typedef enum logic [1:0] {IDLE, MUL, UPD} state_t;
   state_t state_reg, state_next;

   logic [3:0]         nib;
   logic [7:0]         tbl;
   logic               start, kill;
   logic               sgn_reg;
   logic [3:0]         mula_reg;
   logic [7:0]         mulb_reg;
   logic [PBW-1:0]     mcand_reg;
   logic [PAW-1:0]     proda_reg;
   logic [PBW-1:0]     prodb_reg;
   logic [2:0]         cnt_reg;
   logic signed [15:0] x_reg, x_new_reg;
   logic [STEPW-1:0]   step_reg, step_new_reg;
   logic               busy_reg, done_reg;

   logic [15:0]        diff;
   logic [17:0]        x_ext, x_sum;
   logic               x_hi, x_lo;
   logic [15:0]        x_clamped;
   logic [STEPW+1:0]   step_raw;
   logic               step_lo, step_hi;
   logic [STEPW-1:0]   step_clamped;
   logic               unused_bits;

   assign nib   = bus.nibble_sel ? bus.data[3:0] : bus.data[7:4];
   assign start = bus.cen & bus.adv & bus.chon & ~busy_reg;
   assign kill  = bus.clr | (bus.cen & ~bus.chon);

   always_comb begin
      case (nib[2:0])
         3'd4:    tbl = 8'd77;
         3'd5:    tbl = 8'd102;
         3'd6:    tbl = 8'd128;
         3'd7:    tbl = 8'd153;
         default: tbl = 8'd57;
      endcase
   end

   // Update arithmetic: 18-bit signed sum is wide enough for any x +/- diff.
   always_comb begin
      diff      = proda_reg[PAW-1:3];
      x_ext     = {{2{x_reg[15]}}, x_reg};
      x_sum     = sgn_reg ? (x_ext - {2'b00, diff}) : (x_ext + {2'b00, diff});
      x_hi      = ~x_sum[17] & (x_sum[16:15] != 2'b00);
      x_lo      =  x_sum[17] & (x_sum[16:15] != 2'b11);
      x_clamped = x_hi ? 16'h7fff : (x_lo ? 16'h8000 : x_sum[15:0]);
      step_raw  = prodb_reg[PBW-1:6];
      step_lo   = step_raw < (STEPW+2)'(STEP_MIN);
      step_hi   = step_raw > (STEPW+2)'(STEP_MAX);
      step_clamped = step_lo ? STEP_MIN : (step_hi ? STEP_MAX : step_raw[STEPW-1:0]);
   end

   assign unused_bits = ^{proda_reg[2:0], prodb_reg[5:0]};

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // UPD spans two clocks: cnt_reg[0]=0 computes the new values, =1 commits them.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = MUL;
         MUL:     if (cnt_reg == LAST) state_next = UPD;
         UPD:     if (cnt_reg[0]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (kill)
         state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || kill) begin
         x_reg    <= '0;
         step_reg <= STEP_MIN;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: if (start) begin
               sgn_reg   <= nib[3];
               mula_reg  <= {nib[2:0], 1'b1};
               mulb_reg  <= tbl;
               mcand_reg <= PBW'(step_reg);
               proda_reg <= '0;
               prodb_reg <= '0;
               cnt_reg   <= '0;
               busy_reg  <= 1'b1;
            end
            MUL: begin
               if (mula_reg[0]) proda_reg <= proda_reg + mcand_reg[PAW-1:0];
               if (mulb_reg[0]) prodb_reg <= prodb_reg + mcand_reg;
               mula_reg  <= mula_reg >> 1;
               mulb_reg  <= mulb_reg >> 1;
               mcand_reg <= mcand_reg << 1;
               cnt_reg   <= cnt_reg + 3'd1;
            end
            UPD: if (!cnt_reg[0]) begin
               x_new_reg    <= x_clamped;
               step_new_reg <= step_clamped;
               cnt_reg      <= 3'd1;
            end else begin
               x_reg    <= x_new_reg;
               step_reg <= step_new_reg;
               done_reg <= 1'b1;
               busy_reg <= 1'b0;
               cnt_reg  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.pcm  = x_reg;
   assign bus.busy = busy_reg;
   assign bus.done = done_reg;

`ifdef JT10_ADPCMB_SATFLAG_EN
   logic sat_reg, sat_pend_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || kill) begin
         sat_reg      <= 1'b0;
         sat_pend_reg <= 1'b0;
      end else if (state_reg == UPD) begin
         if (!cnt_reg[0])
            sat_pend_reg <= x_hi | x_lo | step_lo | step_hi;
         else
            sat_reg <= sat_reg | sat_pend_reg;
      end
   end

   assign bus.sat = sat_reg;
`endif
endmodule
